// File: rtl/sha256_id_issue_arbiter.sv
// Two-requester, packet-granular round-robin arbiter feeding a SHA-256 engine.
// Each granted packet first issues its ID to the validator, then streams its blocks.
module sha256_id_issue_arbiter (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         en,
  input  logic [511:0] req0_data,
  input  logic         req0_last,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [511:0] req1_data,
  input  logic         req1_last,
  input  logic         req1_valid,
  output logic         req1_ready,
  output logic [511:0] msg_out_data,
  output logic [5:0]   msg_out_id,
  output logic         msg_out_last,
  output logic         msg_out_valid,
  input  logic         msg_out_ready,
  output logic [5:0]   id_out,
  output logic         id_out_src,
  output logic         id_out_valid,
  input  logic         id_out_ready,
  output logic [9:0]   status_packet_count,
  output logic         status_grant
);

  localparam int unsigned DATA_W = 512;
  localparam int unsigned ID_W   = 6;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ID_PUSH = 2'd1,
    STREAM  = 2'd2
  } state_t;

  state_t              state;
  logic                grant;
  logic                prio;
  logic [ID_W-1:0]     id_cnt;
  logic [CNT_W-1:0]    pkt_cnt;

  logic                active;
  logic                in_stream;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic                beat_hs;
  logic                pick;

  // Reset and enable gate every handshake signal combinationally.
  assign active    = en && !sync_rst;
  assign in_stream = active && (state == STREAM);

  assign sel_valid = grant ? req1_valid : req0_valid;
  assign sel_last  = grant ? req1_last  : req0_last;
  assign sel_data  = grant ? req1_data  : req0_data;
  assign beat_hs   = in_stream && sel_valid && msg_out_ready;

  // Priority only matters under contention; a lone requester always wins.
  assign pick = (req0_valid && req1_valid) ? prio : req1_valid;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state   <= ARB;
      grant   <= 1'b0;
      prio    <= 1'b0;
      id_cnt  <= '0;
      pkt_cnt <= '0;
    end else if (en) begin
      case (state)
        ARB: begin
          if (req0_valid || req1_valid) begin
            grant <= pick;
            state <= ID_PUSH;
          end
        end
        ID_PUSH: begin
          if (id_out_ready) state <= STREAM;
        end
        STREAM: begin
          if (beat_hs && sel_last) begin
            id_cnt  <= id_cnt + ID_W'(1);
            pkt_cnt <= pkt_cnt + CNT_W'(1);
            prio    <= ~grant;
            state   <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign id_out        = id_cnt;
  assign id_out_src    = grant;
  assign id_out_valid  = active && (state == ID_PUSH);

  assign msg_out_valid = in_stream && sel_valid;
  assign msg_out_last  = in_stream && sel_last;
  assign msg_out_data  = in_stream ? sel_data : '0;
  assign msg_out_id    = id_cnt;

  assign req0_ready    = in_stream && !grant && msg_out_ready;
  assign req1_ready    = in_stream &&  grant && msg_out_ready;

  assign status_packet_count = pkt_cnt;
  assign status_grant        = grant;

endmodule

// File: tb/tb_sha256_id_issue_arbiter.sv
// Directed scoreboard bench for sha256_id_issue_arbiter: expected IDs and beats
// are queued as packets are offered and retired as the DUT hands them over.
module tb_sha256_id_issue_arbiter;

  typedef struct packed { logic [511:0] d; logic l; }               beat_t;
  typedef struct packed { logic [5:0] id; logic src; }              idexp_t;
  typedef struct packed { logic [511:0] d; logic [5:0] id; logic l; } bexp_t;

  logic         clk;
  logic         sync_rst;
  logic         en;
  logic [511:0] req0_data, req1_data;
  logic         req0_last, req0_valid, req0_ready;
  logic         req1_last, req1_valid, req1_ready;
  logic [511:0] msg_out_data;
  logic [5:0]   msg_out_id;
  logic         msg_out_last, msg_out_valid, msg_out_ready;
  logic [5:0]   id_out;
  logic         id_out_src, id_out_valid, id_out_ready;
  logic [9:0]   status_packet_count;
  logic         status_grant;

  sha256_id_issue_arbiter dut (
    .clk                 (clk),
    .sync_rst            (sync_rst),
    .en                  (en),
    .req0_data           (req0_data),
    .req0_last           (req0_last),
    .req0_valid          (req0_valid),
    .req0_ready          (req0_ready),
    .req1_data           (req1_data),
    .req1_last           (req1_last),
    .req1_valid          (req1_valid),
    .req1_ready          (req1_ready),
    .msg_out_data        (msg_out_data),
    .msg_out_id          (msg_out_id),
    .msg_out_last        (msg_out_last),
    .msg_out_valid       (msg_out_valid),
    .msg_out_ready       (msg_out_ready),
    .id_out              (id_out),
    .id_out_src          (id_out_src),
    .id_out_valid        (id_out_valid),
    .id_out_ready        (id_out_ready),
    .status_packet_count (status_packet_count),
    .status_grant        (status_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t        src0_q[$];
  beat_t        src1_q[$];
  idexp_t       exp_id_q[$];
  bexp_t        exp_b_q[$];

  int           n_chk  = 0;
  int           n_fail = 0;
  int           cyc    = 0;
  int           beat_cnt = 0;
  int           last_cyc = 0;
  logic         nxt_rst = 1'b1, nxt_en = 1'b1, nxt_idr = 1'b1, nxt_mor = 1'b1;
  logic         tog_mor = 1'b0;
  logic         hs0 = 1'b0, hs1 = 1'b0;
  logic         cur_src = 1'b0;
  logic         id_acc = 1'b0;
  logic         chk_gap = 1'b0, have_prev = 1'b0, prev_last = 1'b0;
  logic         stall_pend = 1'b0;
  logic [511:0] stall_data = '0;
  logic [5:0]   exp_id = '0;
  logic [9:0]   exp_cnt = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard and protocol checks, run once per cycle on the falling edge.
  task automatic monitor();
    idexp_t ie;
    bexp_t  be;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (sync_rst) id_acc = 1'b0;
    chk("nongrant_ready", 512'(cur_src ? req0_ready : req1_ready), 512'(0));
    if (stall_pend && en && !sync_rst) begin
      chk("stall_valid", 512'(msg_out_valid), 512'(1));
      chk("stall_data", msg_out_data, stall_data);
    end
    stall_pend = msg_out_valid && !msg_out_ready;
    stall_data = msg_out_data;
    if (id_out_valid && id_out_ready) begin
      chk("id_expected", 512'(exp_id_q.size() != 0), 512'(1));
      if (exp_id_q.size() != 0) begin
        ie = exp_id_q.pop_front();
        chk("id_out", 512'(id_out), 512'(ie.id));
        chk("id_out_src", 512'(id_out_src), 512'(ie.src));
        cur_src = ie.src;
        id_acc  = 1'b1;
      end
    end
    if (msg_out_valid) chk("valid_before_id", 512'(id_acc), 512'(1));
    if (msg_out_valid && msg_out_ready) begin
      chk("beat_expected", 512'(exp_b_q.size() != 0), 512'(1));
      if (exp_b_q.size() != 0) begin
        be = exp_b_q.pop_front();
        chk("beat_data", msg_out_data, be.d);
        chk("beat_id", 512'(msg_out_id), 512'(be.id));
        chk("beat_last", 512'(msg_out_last), 512'(be.l));
      end
      if (chk_gap && have_prev && prev_last) chk("b2b_gap", 512'(cyc - last_cyc), 512'(3));
      last_cyc  = cyc;
      prev_last = msg_out_last;
      have_prev = 1'b1;
      beat_cnt++;
      if (msg_out_last) id_acc = 1'b0;
    end
  endtask

  task automatic cycle();
    beat_t b;
    @(posedge clk);
    #1;
    en           = nxt_en;
    sync_rst     = nxt_rst;
    id_out_ready = nxt_idr;
    msg_out_ready = tog_mor ? ~msg_out_ready : nxt_mor;
    if (hs0 && src0_q.size() != 0) b = src0_q.pop_front();
    if (hs1 && src1_q.size() != 0) b = src1_q.pop_front();
    hs0 = 1'b0;
    hs1 = 1'b0;
    req0_valid = (src0_q.size() != 0);
    req0_data  = req0_valid ? src0_q[0].d : '0;
    req0_last  = req0_valid ? src0_q[0].l : 1'b0;
    req1_valid = (src1_q.size() != 0);
    req1_data  = req1_valid ? src1_q[0].d : '0;
    req1_last  = req1_valid ? src1_q[0].l : 1'b0;
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  // Queue one packet on a requester and its expected ID and beats, in grant order.
  task automatic add_pkt(input logic src, input int nb);
    beat_t  b;
    bexp_t  e;
    idexp_t ie;
    ie.id  = exp_id;
    ie.src = src;
    exp_id_q.push_back(ie);
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < 16; k++) b.d[32*k +: 32] = $urandom;
      b.l = (i == nb - 1);
      if (src) src1_q.push_back(b);
      else     src0_q.push_back(b);
      e.d  = b.d;
      e.id = exp_id;
      e.l  = b.l;
      exp_b_q.push_back(e);
    end
    exp_id  = exp_id + 6'd1;
    exp_cnt = exp_cnt + 10'd1;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 ||
            exp_id_q.size() != 0 || exp_b_q.size() != 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", 512'(n < max_cyc), 512'(1));
    cycle();
  endtask

  task automatic do_reset();
    nxt_rst = 1'b1;
    cycle();
    chk("rst_req0_ready", 512'(req0_ready), 512'(0));
    chk("rst_req1_ready", 512'(req1_ready), 512'(0));
    chk("rst_id_valid", 512'(id_out_valid), 512'(0));
    chk("rst_msg_valid", 512'(msg_out_valid), 512'(0));
    cycle();
    src0_q.delete();
    src1_q.delete();
    exp_id_q.delete();
    exp_b_q.delete();
    exp_id    = '0;
    exp_cnt   = '0;
    cur_src   = 1'b0;
    id_acc    = 1'b0;
    have_prev = 1'b0;
    nxt_rst   = 1'b0;
    cycle();
    chk("rst_count", 512'(status_packet_count), 512'(0));
    chk("rst_grant", 512'(status_grant), 512'(0));
    chk("rst_id_out", 512'(id_out), 512'(0));
    chk("rst_msg_data", msg_out_data, 512'(0));
  endtask

  initial begin
    int   b0;
    logic [5:0] pkt_id;
    sync_rst = 1'b1; en = 1'b1; id_out_ready = 1'b1; msg_out_ready = 1'b1;
    req0_valid = 1'b0; req0_last = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_last = 1'b0; req1_data = '0;

    do_reset();

    // Single 3-block packet with minimum latency.
    add_pkt(1'b0, 3);
    cycle();
    chk("lat_n_id_valid", 512'(id_out_valid), 512'(0));
    cycle();
    chk("lat_n1_id_valid", 512'(id_out_valid), 512'(1));
    chk("lat_n1_msg_valid", 512'(msg_out_valid), 512'(0));
    cycle();
    chk("lat_n2_msg_valid", 512'(msg_out_valid), 512'(1));
    drain(50);
    chk("single_count", 512'(status_packet_count), 512'(exp_cnt));

    // Contention: alternating grants and back-to-back spacing.
    do_reset();
    have_prev = 1'b0;
    chk_gap   = 1'b1;
    add_pkt(1'b0, 2);
    add_pkt(1'b1, 2);
    add_pkt(1'b0, 2);
    add_pkt(1'b1, 2);
    drain(100);
    chk_gap = 1'b0;
    chk("contention_count", 512'(status_packet_count), 512'(4));
    chk("contention_grant", 512'(status_grant), 512'(1));

    // ID back-pressure, then toggled msg_out_ready.
    nxt_idr = 1'b0;
    pkt_id  = exp_id;
    add_pkt(1'b0, 4);
    for (int i = 0; i < 10 && !id_out_valid; i++) cycle();
    chk("bp_id_valid_seen", 512'(id_out_valid), 512'(1));
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_id_valid", 512'(id_out_valid), 512'(1));
      chk("bp_id_hold", 512'(id_out), 512'(pkt_id));
      chk("bp_no_msg", 512'(msg_out_valid), 512'(0));
    end
    nxt_idr = 1'b1;
    tog_mor = 1'b1;
    drain(100);
    tog_mor = 1'b0;
    nxt_mor = 1'b1;
    chk("bp_count", 512'(status_packet_count), 512'(exp_cnt));

    // ID and packet-count wrap.
    do_reset();
    for (int i = 0; i < 65; i++) add_pkt(1'b0, 1);
    drain(1000);
    chk("wrap65_count", 512'(status_packet_count), 512'(65));
    chk("wrap65_id_next", 512'(id_out), 512'(1));
    for (int i = 0; i < 958; i++) add_pkt(1'b0, 1);
    drain(5000);
    chk("wrap1023_count", 512'(status_packet_count), 512'(1023));
    add_pkt(1'b1, 1);
    drain(50);
    chk("wrap1024_count", 512'(status_packet_count), 512'(0));

    // Enable dropped mid-stream.
    add_pkt(1'b1, 5);
    b0 = beat_cnt;
    for (int i = 0; i < 50 && beat_cnt < b0 + 2; i++) cycle();
    chk("en_two_beats", 512'(beat_cnt >= b0 + 2), 512'(1));
    b0 = beat_cnt;
    nxt_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("en0_req0_ready", 512'(req0_ready), 512'(0));
      chk("en0_req1_ready", 512'(req1_ready), 512'(0));
      chk("en0_id_valid", 512'(id_out_valid), 512'(0));
      chk("en0_msg_valid", 512'(msg_out_valid), 512'(0));
    end
    chk("en0_no_beats", 512'(beat_cnt), 512'(b0));
    nxt_en = 1'b1;
    drain(50);
    chk("en_count", 512'(status_packet_count), 512'(exp_cnt));

    // Reset in the middle of a req1 packet.
    add_pkt(1'b1, 4);
    b0 = beat_cnt;
    for (int i = 0; i < 50 && beat_cnt < b0 + 1; i++) cycle();
    chk("midrst_beat_seen", 512'(beat_cnt >= b0 + 1), 512'(1));
    do_reset();
    add_pkt(1'b0, 2);
    add_pkt(1'b1, 1);
    drain(50);
    chk("midrst_count", 512'(status_packet_count), 512'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_id_issue_arbiter.md
SHA256_ID_ISSUE_ARBITER -- requirements
Module: sha256_id_issue_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: sync_rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: en  in  1  enable; low freezes the block.
REQ-004 SHALL have ports: req0_data  in  512  requester 0 message block.
REQ-005 SHALL have ports: req0_last/req0_valid  in  1 each  requester 0 last-block flag and valid; req0_ready  out  1.
REQ-006 SHALL have ports: req1_data  in  512; req1_last/req1_valid  in  1 each; req1_ready  out  1 (requester 1, same meaning as requester 0).
REQ-007 SHALL have ports: msg_out_data  out  512; msg_out_id  out  6; msg_out_last/msg_out_valid  out  1 each; msg_out_ready  in  1 (to hash engine).
REQ-008 SHALL have ports: id_out  out  6; id_out_src  out  1 (granted requester); id_out_valid  out  1; id_out_ready  in  1 (to validator ID buffer).
REQ-009 SHALL have ports: status_packet_count  out  10  packets completed; status_grant  out  1  current or last granted requester.

Function
REQ-010 SHALL implement FSM states ARB, ID_PUSH, STREAM; reset state ARB.
REQ-011 In ARB with en=1 and any reqN_valid=1, SHALL grant at packet granularity, register the grant, and enter ID_PUSH next cycle.
REQ-012 Arbitration SHALL be round-robin: the requester not granted last has priority; after reset requester 0 has priority.
REQ-013 With only one requester valid, SHALL grant it regardless of priority.
REQ-014 In ID_PUSH, id_out_valid SHALL be 1, id_out SHALL equal the ID counter and id_out_src the grant; id_out SHALL hold until id_out_ready=1, then enter STREAM.
REQ-015 In STREAM, msg_out_valid/data/last SHALL combinationally follow the granted requester, reqG_ready SHALL equal msg_out_ready, and msg_out_id SHALL equal the captured ID.
REQ-016 The non-granted requester's ready SHALL be 0 in every state; both readies SHALL be 0 outside STREAM.
REQ-017 On a STREAM handshake with last=1, SHALL increment the ID counter mod 64 (63 -> 0), increment status_packet_count mod 1024 (1023 -> 0), record the grant for round-robin, and return to ARB.
REQ-018 Minimum latency: requester valid in ARB at cycle N -> id_out_valid at N+1 -> with id_out_ready=1 at N+1, first msg_out handshake possible at N+2.
REQ-019 Back-to-back packets SHALL incur exactly one ARB cycle and one ID_PUSH cycle between the last beat of one packet and the first beat of the next.
REQ-020 With en=0, all valid and ready outputs SHALL be 0 and all state SHALL hold; on return to en=1, operation SHALL resume from the held state.
REQ-021 msg_out_valid SHALL never be 1 unless the ID for that packet has already been accepted on id_out.

Reset
REQ-022 While sync_rst=1, all valid and ready outputs SHALL be forced 0 combinationally.
REQ-023 On the next edge after sync_rst=1, SHALL set state=ARB, ID counter=0, status_packet_count=0, status_grant=0, priority=requester 0, and all data outputs=0.
REQ-024 Reset mid-packet SHALL abandon the packet without counting it; the next packet SHALL receive ID 0.

Verification
REQ-025 Single packet: req0 sends 3 blocks, last on the 3rd -> id_out=0 and src=0 accepted once; msg_out carries 3 beats with id 0; count=1.
REQ-026 Contention: both requesters are continuously valid with 2-block packets -> grants alternate 0,1,0,1; IDs are 0,1,2,3; count=4; the non-granted ready never goes high.
REQ-027 Back-pressure: id_out_ready is held low for 5 cycles -> id_out stable, no msg_out_valid; msg_out_ready toggled -> data held, no beats lost or duplicated.
REQ-028 Wrap: 65 single-block packets -> 65th packet id=0; preset 1023 packets then 1 more -> count=0.
REQ-029 en=0 mid-STREAM for 4 cycles -> all valid and ready outputs are 0 and no beats transfer; en=1 -> the remaining beats complete with the same ID.
REQ-030 sync_rst pulsed mid-packet from req1 -> readies are 0 during reset; afterwards req0 and req1 both valid -> req0 granted with ID 0 and count=0.
